instr_encoder_loader: RTL and testbench

Streaming instruction encoder and program loader for the 16-bit CPU. It is the writer side of the opcode decoder.
- Accepts symbolic instruction requests (opcode, Rx, Ry, immediate/target) over a valid/ready handshake.
- Packs each request into a 16-bit instruction word.
- Writes words sequentially into instruction memory from BASE_ADDR, stepping by 2 bytes (PC+2 convention).
- Used by the boot/test harness to load programs without an external assembler.

---
 rtl/instr_pkg.sv | 46 ++++
 rtl/instr_encoder_loader_if.sv | 19 +
 rtl/instr_field_packer.sv | 79 +++++++
 rtl/instr_encoder_loader.sv | 95 +++++++++
 tb/tb_instr_encoder_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-set constants for the 16-bit CPU.
// Both the encoder/loader and the opcode decoder import this package.
package instr_pkg;

    localparam logic [4:0] OP_MV    = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_CMP   = 5'b00011;
    localparam logic [4:0] OP_LD    = 5'b00100;
    localparam logic [4:0] OP_ST    = 5'b00101;
    localparam logic [4:0] OP_JR    = 5'b01000;
    localparam logic [4:0] OP_JZR   = 5'b01001;
    localparam logic [4:0] OP_JNR   = 5'b01010;
    localparam logic [4:0] OP_CALLR = 5'b01100;
    localparam logic [4:0] OP_MVI   = 5'b10000;
    localparam logic [4:0] OP_ADDI  = 5'b10001;
    localparam logic [4:0] OP_SUBI  = 5'b10010;
    localparam logic [4:0] OP_CMPI  = 5'b10011;
    localparam logic [4:0] OP_MVHI  = 5'b10110;
    localparam logic [4:0] OP_J     = 5'b11000;
    localparam logic [4:0] OP_JZ    = 5'b11001;
    localparam logic [4:0] OP_JN    = 5'b11010;
    localparam logic [4:0] OP_CALL  = 5'b11100;

    // Field positions inside the instruction word
    localparam int OPC_LSB  = 0;
    localparam int RX_LSB   = 5;
    localparam int RY_LSB   = 8;
    localparam int IMM8_LSB = 8;
    localparam int BR_LSB   = 5;
    localparam int BR_W     = 11;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_IMM    = 2'b10,
        ERR_BRANCH = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FULL = 2'b10
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Symbolic instruction request channel (valid/ready) from harness to loader.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [2:0]  in_rx;
    logic [2:0]  in_ry;
    logic [15:0] in_imm;

    modport master (
        output in_valid, in_opcode, in_rx, in_ry, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rx, in_ry, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational packer: turns one symbolic request into a 16-bit word,
// or flags why it cannot be encoded.
module instr_field_packer
    import instr_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [4:0]    opcode,
    input  logic [2:0]    rx,
    input  logic [2:0]    ry,
    input  logic [15:0]   imm,
    input  logic [AW-1:0] addr,
    output logic [15:0]   word,
    output logic          err,
    output err_code_e     err_code
);

    // Wide enough that target - (addr + 2) never overflows
    localparam int BW = ((AW > 16) ? AW : 16) + 2;

    logic [BW-1:0] target;
    logic [BW-1:0] next_pc;
    logic [BW-1:0] diff;
    logic [BW-1:0] offset;
    logic          imm8_ok;
    logic          offset_ok;

    always_comb begin
        target    = BW'(imm);
        next_pc   = BW'(addr) + BW'(2);
        diff      = target - next_pc;
        offset    = BW'($signed(diff) >>> 1);
        imm8_ok   = (imm[15:7] == '0) || (imm[15:7] == '1);
        offset_ok = (offset[BW-1:10] == '0) || (offset[BW-1:10] == '1);

        word     = '0;
        err      = 1'b0;
        err_code = ERR_NONE;
        word[OPC_LSB +: 5] = opcode;

        case (opcode)
            OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST: begin
                word[RX_LSB +: 3] = rx;
                word[RY_LSB +: 3] = ry;
            end
            OP_JR, OP_JZR, OP_JNR, OP_CALLR: begin
                word[RX_LSB +: 3] = rx;
            end
            OP_MVI, OP_ADDI, OP_SUBI, OP_CMPI: begin
                word[RX_LSB +: 3]   = rx;
                word[IMM8_LSB +: 8] = imm[7:0];
                if (!imm8_ok) begin
                    err      = 1'b1;
                    err_code = ERR_IMM;
                end
            end
            OP_MVHI: begin
                word[RX_LSB +: 3]   = rx;
                word[IMM8_LSB +: 8] = imm[15:8];
                if (imm[7:0] != 8'h00) begin
                    err      = 1'b1;
                    err_code = ERR_IMM;
                end
            end
            OP_J, OP_JZ, OP_JN, OP_CALL: begin
                word[BR_LSB +: BR_W] = offset[BR_W-1:0];
                if (imm[0] || !offset_ok) begin
                    err      = 1'b1;
                    err_code = ERR_BRANCH;
                end
            end
            default: begin
                err      = 1'b1;
                err_code = ERR_OPCODE;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes accepted requests and writes them sequentially
// into instruction memory from BASE_ADDR, two bytes per word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, no load in progress, requests not accepted
// ST_RUN  | loading; requests accepted while start is low
// ST_FULL | END_ADDR written; requests refused until the next start
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int            AW        = 16,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter logic [AW-1:0] END_ADDR  = AW'(16'hFFFE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    instr_encoder_loader_if.slave  req,
    output logic [AW-1:0]          mem_addr,
    output logic [15:0]            mem_wdata,
    output logic                   mem_we,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [AW-1:0]          word_count,
    output logic                   full
);

    state_e        state;
    logic [AW-1:0] ptr;
    logic          we_q;
    logic          accept;
    logic [15:0]   pk_word;
    logic          pk_err;
    err_code_e     pk_code;

    assign req.in_ready = (state == ST_RUN) && !start;
    assign accept       = req.in_valid && req.in_ready;
    // A start in the cycle after an accept cancels that write
    assign mem_we       = we_q && !start;

    instr_field_packer #(.AW(AW)) u_packer (
        .opcode   (req.in_opcode),
        .rx       (req.in_rx),
        .ry       (req.in_ry),
        .imm      (req.in_imm),
        .addr     (ptr),
        .word     (pk_word),
        .err      (pk_err),
        .err_code (pk_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= BASE_ADDR;
            word_count <= '0;
            full       <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            we_q <= 1'b0;
            err  <= 1'b0;
            if (start) begin
                state      <= ST_RUN;
                ptr        <= BASE_ADDR;
                word_count <= '0;
                full       <= 1'b0;
            end else if (accept) begin
                if (pk_err) begin
                    err      <= 1'b1;
                    err_code <= pk_code;
                end else begin
                    we_q      <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= pk_word;
                    if (word_count != '1) begin
                        word_count <= word_count + AW'(1);
                    end
                    // Pointer parks on END_ADDR rather than running past it
                    if (ptr == END_ADDR) begin
                        full  <= 1'b1;
                        state <= ST_FULL;
                    end else begin
                        ptr <= ptr + AW'(2);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed plus randomized bench for instr_encoder_loader against a
// behavioural model of the loader and the encoding rules.
module tb_instr_encoder_loader;
    import instr_pkg::*;

    localparam int          AW   = 16;
    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [15:0] ENDA = 16'h0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] word_count;
    logic        full;

    instr_encoder_loader_if req_if();

    instr_encoder_loader #(.AW(AW), .BASE_ADDR(BASE), .END_ADDR(ENDA)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req        (req_if),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .err        (err),
        .err_code   (err_code),
        .word_count (word_count),
        .full       (full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_ptr;
    int          m_count;
    bit          m_run;
    bit          m_full;
    bit          p_we;
    bit          p_err;
    logic [15:0] p_addr;
    logic [15:0] p_data;
    logic [1:0]  p_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Encoding rules computed with plain integer arithmetic; code 0 = encodable
    function automatic void model_enc(input int op, input int rx, input int ry,
                                      input int imm, input int addr,
                                      output int w, output int code);
        int simm;
        int off;
        w    = 0;
        code = 0;
        case (op)
            0, 1, 2, 3, 4, 5:  w = op + rx * 32 + ry * 256;
            8, 9, 10, 12:      w = op + rx * 32;
            16, 17, 18, 19: begin
                simm = (imm >= 32768) ? imm - 65536 : imm;
                if (simm < -128 || simm > 127) code = 2;
                else w = op + rx * 32 + (imm % 256) * 256;
            end
            22: begin
                if (imm % 256 != 0) code = 2;
                else w = op + rx * 32 + (imm / 256) * 256;
            end
            24, 25, 26, 28: begin
                if (imm % 2 != 0) code = 3;
                else begin
                    off = (imm - (addr + 2)) / 2;
                    if (off < -1024 || off > 1023) code = 3;
                    else w = op + ((off + 2048) % 2048) * 32;
                end
            end
            default: code = 1;
        endcase
    endfunction

    // Drive one cycle at the negedge, check outputs, advance the model, move to next negedge
    task automatic cycle(input bit r, input bit st, input bit v, input int op,
                         input int rx, input int ry, input int imm);
        int w;
        int code;
        reset            = r;
        start            = st;
        req_if.in_valid  = v;
        req_if.in_opcode = op[4:0];
        req_if.in_rx     = rx[2:0];
        req_if.in_ry     = ry[2:0];
        req_if.in_imm    = imm[15:0];
        #1;
        chk("in_ready",   {31'b0, req_if.in_ready}, {31'b0, m_run && !st});
        chk("mem_we",     {31'b0, mem_we},          {31'b0, p_we && !st});
        chk("mem_addr",   {16'b0, mem_addr},        {16'b0, p_addr});
        chk("mem_wdata",  {16'b0, mem_wdata},       {16'b0, p_data});
        chk("err",        {31'b0, err},             {31'b0, p_err});
        chk("err_code",   {30'b0, err_code},        {30'b0, p_code});
        chk("word_count", {16'b0, word_count},      m_count);
        chk("full",       {31'b0, full},            {31'b0, m_full});

        if (r) begin
            m_run = 0; m_full = 0; m_ptr = BASE; m_count = 0;
            p_we = 0; p_err = 0; p_addr = '0; p_data = '0; p_code = '0;
        end else begin
            p_we  = 0;
            p_err = 0;
            if (st) begin
                m_ptr = BASE; m_count = 0; m_full = 0; m_run = 1;
            end else if (v && m_run) begin
                model_enc(op, rx, ry, imm, m_ptr, w, code);
                if (code != 0) begin
                    p_err  = 1;
                    p_code = code[1:0];
                end else begin
                    p_we   = 1;
                    p_addr = m_ptr[15:0];
                    p_data = w[15:0];
                    if (m_count < 65535) m_count++;
                    if (m_ptr == int'(ENDA)) begin
                        m_full = 1;
                        m_run  = 0;
                    end else begin
                        m_ptr += 2;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    int ops[19] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 12, 16, 17, 18, 19, 22, 24, 25, 26, 28};

    initial begin
        int op;
        int imm;
        reset = 1'b1;
        start = 1'b0;
        req_if.in_valid  = 1'b0;
        req_if.in_opcode = '0;
        req_if.in_rx     = '0;
        req_if.in_ry     = '0;
        req_if.in_imm    = '0;
        m_run = 0; m_full = 0; m_ptr = BASE; m_count = 0;
        p_we = 0; p_err = 0; p_addr = '0; p_data = '0; p_code = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, idle ignores requests
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 2, 0);

        // add, mvi, out-of-range mvi, backward branch to END_ADDR
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 2, 0);
        chk("add_we",   {31'b0, mem_we},    32'h1);
        chk("add_addr", {16'b0, mem_addr},  32'h0000);
        chk("add_word", {16'b0, mem_wdata}, 32'h0221);
        cycle(0, 0, 1, 16, 3, 0, 16'hFFFF);
        chk("mvi_addr",  {16'b0, mem_addr},   32'h0002);
        chk("mvi_word",  {16'b0, mem_wdata},  32'hFF70);
        chk("mvi_count", {16'b0, word_count}, 32'd2);
        cycle(0, 0, 1, 16, 0, 0, 200);
        chk("mvi200_err",  {31'b0, err},      32'h1);
        chk("mvi200_code", {30'b0, err_code}, 32'h2);
        chk("mvi200_we",   {31'b0, mem_we},   32'h0);
        cycle(0, 0, 1, 24, 0, 0, 0);
        chk("jback_addr", {16'b0, mem_addr},  32'h0004);
        chk("jback_word", {16'b0, mem_wdata}, 32'hFFB8);
        chk("jback_full", {31'b0, full},      32'h1);
        cycle(0, 0, 1, 1, 2, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Illegal opcode, odd branch target, branch range edge
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 6, 1, 1, 0);
        chk("illegal_code", {30'b0, err_code}, 32'h1);
        cycle(0, 0, 1, 25, 0, 0, 5);
        chk("odd_tgt_code", {30'b0, err_code}, 32'h3);
        cycle(0, 0, 1, 24, 0, 0, 2048);
        chk("br_max_word", {16'b0, mem_wdata}, 32'h7FF8);
        cycle(0, 0, 1, 24, 0, 0, 2052);
        chk("br_over_code", {30'b0, err_code}, 32'h3);
        cycle(0, 0, 1, 16, 7, 0, 16'hFF80);
        cycle(0, 0, 1, 22, 5, 0, 16'h1234);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Fill: three back-to-back writes, fourth ignored
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 2, 4, 5, 0);
        cycle(0, 0, 1, 9, 6, 0, 0);
        cycle(0, 0, 1, 22, 1, 0, 16'hAB00);
        chk("fill_addr", {16'b0, mem_addr}, 32'h0004);
        chk("fill_full", {31'b0, full},     32'h1);
        cycle(0, 0, 1, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Restart right after an accept drops that write
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 2, 2, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 3, 4, 0);
        chk("restart_addr",  {16'b0, mem_addr},   32'h0000);
        chk("restart_count", {16'b0, word_count}, 32'd1);

        // Reset mid-load
        cycle(0, 0, 1, 4, 1, 1, 0);
        cycle(1, 0, 1, 5, 1, 1, 0);
        cycle(0, 0, 1, 5, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) < 14) op = ops[$urandom_range(0, 18)];
            else op = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: imm = $urandom_range(0, 65535);
                1: imm = (int'($urandom_range(0, 511)) - 256) & 16'hFFFF;
                2: imm = $urandom_range(0, 255) << 8;
                default: imm = (m_ptr + int'($urandom_range(0, 4200)) - 2100) & 16'hFFFF;
            endcase
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0, op,
                  $urandom_range(0, 7), $urandom_range(0, 7), imm);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
